// File: rtl/cpu_control_unit_if.sv
// Bus between the control unit, the program memory and the ALU/register file.
// The control unit drives addresses, strobes and flags; memory and ALU return
// the instruction byte and the ALU status flags.
interface cpu_control_unit_if;
  logic [7:0] mem_data;
  logic       alu_z;
  logic       alu_c;
  logic [7:0] pc;
  logic [3:0] alu_sel;
  logic [3:0] reg_addr;
  logic       accum_we;
  logic [1:0] accum_src;
  logic       reg_we;
  logic [7:0] imm;
  logic       zf;
  logic       cf;
  logic       halted;

  modport master (
    input  mem_data, alu_z, alu_c,
    output pc, alu_sel, reg_addr, accum_we, accum_src, reg_we, imm, zf, cf, halted
  );

  modport slave (
    output mem_data, alu_z, alu_c,
    input  pc, alu_sel, reg_addr, accum_we, accum_src, reg_we, imm, zf, cf, halted
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for a small accumulator CPU.
// Fetches one- or two-byte instructions from a combinational program memory,
// sequences the ALU and accumulator/register-file strobes, and holds the
// architectural zero/carry flags. All strobes are decoded from the current
// state, so an asynchronous reset clears them in the same instant.
module cpu_control_unit (
  input  logic                       clk,
  input  logic                       rst,
  cpu_control_unit_if.master         ctrl_io
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZ   = 4'b0110;
  localparam logic [3:0] OP_JC   = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LDI  = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_REG = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       zf_q, zf_d;
  logic       cf_q, cf_d;

  logic [3:0] opcode;
  logic [3:0] alu_sel_o;
  logic       accum_we_o;
  logic [1:0] accum_src_o;
  logic       reg_we_o;
  logic       halted_o;

  assign opcode = ir_q[7:4];

  function automatic logic isAluOp(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
           (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic isTwoByte(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

  // State and architectural registers; reset returns the machine to FETCH at 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  // Next-state logic: instruction sequencing, pc updates, branch resolution and flag capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = ctrl_io.mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (isTwoByte(opcode)) begin
          state_d = S_FETCH_IMM;
        end else if (isAluOp(opcode) || (opcode == OP_MOVR) || (opcode == OP_MOVA)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH_IMM: begin
        imm_d   = ctrl_io.mem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_JMP:  pc_d = imm_q;
          OP_JZ:   if (zf_q) pc_d = imm_q;
          OP_JC:   if (cf_q) pc_d = imm_q;
          default: pc_d = pc_q;
        endcase
        state_d = isAluOp(opcode) ? S_WB : S_FETCH;
      end
      S_WB: begin
        zf_d    = ctrl_io.alu_z;
        cf_d    = ctrl_io.alu_c;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output decode: ALU select and single-cycle write strobes derived from state and opcode.
  always_comb begin
    alu_sel_o   = OP_NOP;
    accum_we_o  = 1'b0;
    accum_src_o = SRC_ALU;
    reg_we_o    = 1'b0;
    halted_o    = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (isAluOp(opcode)) begin
          alu_sel_o = opcode;
        end
        case (opcode)
          OP_MOVR: begin
            accum_we_o  = 1'b1;
            accum_src_o = SRC_REG;
          end
          OP_MOVA: begin
            reg_we_o = 1'b1;
          end
          OP_LDI: begin
            accum_we_o  = 1'b1;
            accum_src_o = SRC_IMM;
          end
          default: begin
            accum_we_o = 1'b0;
          end
        endcase
      end
      S_WB: begin
        alu_sel_o   = opcode;
        accum_we_o  = 1'b1;
        accum_src_o = SRC_ALU;
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        halted_o = 1'b0;
      end
    endcase
  end

  assign ctrl_io.pc        = pc_q;
  assign ctrl_io.imm       = imm_q;
  assign ctrl_io.zf        = zf_q;
  assign ctrl_io.cf        = cf_q;
  assign ctrl_io.reg_addr  = ir_q[3:0];
  assign ctrl_io.alu_sel   = alu_sel_o;
  assign ctrl_io.accum_we  = accum_we_o;
  assign ctrl_io.accum_src = accum_src_o;
  assign ctrl_io.reg_we    = reg_we_o;
  assign ctrl_io.halted    = halted_o;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: small directed programs in a model program
// memory, with write strobes checked by a scoreboard monitor and pc/flags/alu_sel
// checked at hand-computed cycles.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem [256];
  logic       aluZ = 1'b0;
  logic       aluC = 1'b0;
  int         nChecks = 0;
  int         nFail = 0;
  int         cyc;

  typedef struct {
    int         cyc;
    logic       accumWe;
    logic       regWe;
    logic [1:0] src;
    logic [3:0] regAddr;
    logic [3:0] aluSel;
  } strobe_t;

  strobe_t expQ[$];

  cpu_control_unit_if bus();

  assign bus.mem_data = mem[bus.pc];
  assign bus.alu_z    = aluZ;
  assign bus.alu_c    = aluC;

  cpu_control_unit dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle number of the current instruction stream; cycle 1 is the first FETCH after reset.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expectStrobe(input int c, input logic aw, input logic rw,
                              input logic [1:0] src, input logic [3:0] ra, input logic [3:0] sel);
    strobe_t e;
    e.cyc = c; e.accumWe = aw; e.regWe = rw; e.src = src; e.regAddr = ra; e.aluSel = sel;
    expQ.push_back(e);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Pulse reset, release it on a falling edge and settle inside cycle 1.
  task automatic applyStimulus();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write strobe seen on a falling edge must match the next expected entry.
  initial begin
    strobe_t e;
    forever begin
      @(negedge clk);
      if (bus.accum_we === 1'b1 || bus.reg_we === 1'b1) begin
        checkOutput("we_exclusive", {31'd0, bus.accum_we & bus.reg_we}, 32'd0);
        if (expQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_strobe: accum_we=%b reg_we=%b at cycle %0d, none expected",
                   bus.accum_we, bus.reg_we, cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("strobe_cycle", cyc, e.cyc);
          checkOutput("strobe_accum_we", {31'd0, bus.accum_we}, {31'd0, e.accumWe});
          checkOutput("strobe_reg_we", {31'd0, bus.reg_we}, {31'd0, e.regWe});
          if (e.accumWe) checkOutput("strobe_accum_src", {30'd0, bus.accum_src}, {30'd0, e.src});
          checkOutput("strobe_reg_addr", {28'd0, bus.reg_addr}, {28'd0, e.regAddr});
          checkOutput("strobe_alu_sel", {28'd0, bus.alu_sel}, {28'd0, e.aluSel});
        end
      end
    end
  end

  // Directed programs.
  initial begin
    int selLdiAdd [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int selAddAdd [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    clearMem();
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_pc", {24'd0, bus.pc}, 32'h00);
    checkOutput("reset_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    checkOutput("reset_imm", {24'd0, bus.imm}, 32'h00);
    checkOutput("reset_flags", {30'd0, bus.zf, bus.cf}, 32'd0);
    checkOutput("reset_strobes", {29'd0, bus.accum_we, bus.reg_we, bus.halted}, 32'd0);
    checkOutput("reset_accum_src", {30'd0, bus.accum_src}, 32'd0);

    $display("[TB] LDI 05 ; ADD r1");
    clearMem();
    mem[8'h00] = 8'h91; mem[8'h01] = 8'h05; mem[8'h02] = 8'h11;
    aluZ = 1'b0; aluC = 1'b1;
    expectStrobe(4, 1'b1, 1'b0, 2'b10, 4'h1, 4'h0);
    expectStrobe(8, 1'b1, 1'b0, 2'b00, 4'h1, 4'h1);
    applyStimulus();
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("ldi_add_alu_sel_c%0d", c + 1), {28'd0, bus.alu_sel}, selLdiAdd[c]);
      step(1);
    end
    checkOutput("ldi_add_pc", {24'd0, bus.pc}, 32'h03);
    checkOutput("ldi_add_cf", {31'd0, bus.cf}, 32'd1);
    checkOutput("ldi_add_zf", {31'd0, bus.zf}, 32'd0);
    checkOutput("ldi_add_imm", {24'd0, bus.imm}, 32'h05);
    checkOutput("ldi_add_drained", expQ.size(), 32'd0);

    $display("[TB] ADD r2 ; ADD r2 ; HALT");
    clearMem();
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h12; mem[8'h02] = 8'hF0;
    aluZ = 1'b1; aluC = 1'b0;
    expectStrobe(4, 1'b1, 1'b0, 2'b00, 4'h2, 4'h1);
    expectStrobe(8, 1'b1, 1'b0, 2'b00, 4'h2, 4'h1);
    applyStimulus();
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("add_add_alu_sel_c%0d", c + 1), {28'd0, bus.alu_sel}, selAddAdd[c]);
      step(1);
    end
    checkOutput("add_add_zf", {31'd0, bus.zf}, 32'd1);
    checkOutput("add_add_cf", {31'd0, bus.cf}, 32'd0);
    checkOutput("add_add_pc", {24'd0, bus.pc}, 32'h02);
    step(2);
    checkOutput("add_add_halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("add_add_halt_pc", {24'd0, bus.pc}, 32'h03);
    checkOutput("add_add_drained", expQ.size(), 32'd0);

    $display("[TB] ADD ; JMP FE ; JC 20 across the pc wrap");
    clearMem();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h80; mem[8'h02] = 8'hFE;
    mem[8'hFE] = 8'h70; mem[8'hFF] = 8'h20; mem[8'h20] = 8'hF0;
    aluZ = 1'b0; aluC = 1'b1;
    expectStrobe(4, 1'b1, 1'b0, 2'b00, 4'h1, 4'h1);
    applyStimulus();
    step(8);
    checkOutput("jmp_pc", {24'd0, bus.pc}, 32'hFE);
    checkOutput("jmp_cf", {31'd0, bus.cf}, 32'd1);
    step(4);
    checkOutput("jc_wrap_pc", {24'd0, bus.pc}, 32'h20);
    checkOutput("jc_wrap_imm", {24'd0, bus.imm}, 32'h20);
    checkOutput("jc_flags", {30'd0, bus.zf, bus.cf}, 32'b01);
    step(3);
    checkOutput("jc_halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("jc_halt_pc", {24'd0, bus.pc}, 32'h21);
    checkOutput("jc_drained", expQ.size(), 32'd0);

    $display("[TB] SUB ; JZ 40 taken");
    clearMem();
    mem[8'h00] = 8'h22; mem[8'h01] = 8'h60; mem[8'h02] = 8'h40; mem[8'h40] = 8'hF0;
    aluZ = 1'b1; aluC = 1'b1;
    expectStrobe(4, 1'b1, 1'b0, 2'b00, 4'h2, 4'h2);
    applyStimulus();
    step(8);
    checkOutput("jz_taken_pc", {24'd0, bus.pc}, 32'h40);
    checkOutput("jz_taken_flags", {30'd0, bus.zf, bus.cf}, 32'b11);

    $display("[TB] ADD ; JZ 40 not taken");
    clearMem();
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h60; mem[8'h02] = 8'h40; mem[8'h03] = 8'hF0;
    aluZ = 1'b0; aluC = 1'b1;
    expectStrobe(4, 1'b1, 1'b0, 2'b00, 4'h1, 4'h1);
    applyStimulus();
    step(8);
    checkOutput("jz_not_taken_pc", {24'd0, bus.pc}, 32'h03);
    checkOutput("jz_not_taken_flags", {30'd0, bus.zf, bus.cf}, 32'b01);
    checkOutput("jz_not_taken_imm", {24'd0, bus.imm}, 32'h40);
    checkOutput("jz_drained", expQ.size(), 32'd0);

    $display("[TB] NOP ; undefined ; MOVA r7 ; MOVR r3");
    clearMem();
    mem[8'h00] = 8'h00; mem[8'h01] = 8'hA5; mem[8'h02] = 8'h57;
    mem[8'h03] = 8'h43; mem[8'h04] = 8'hF0;
    aluZ = 1'b1; aluC = 1'b1;
    expectStrobe(7, 1'b0, 1'b1, 2'b00, 4'h7, 4'h0);
    expectStrobe(10, 1'b1, 1'b0, 2'b01, 4'h3, 4'h0);
    applyStimulus();
    step(4);
    checkOutput("nop_undef_pc", {24'd0, bus.pc}, 32'h02);
    step(6);
    checkOutput("mov_pc", {24'd0, bus.pc}, 32'h04);
    checkOutput("mov_flags", {30'd0, bus.zf, bus.cf}, 32'b00);
    step(3);
    checkOutput("mov_halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("mov_drained", expQ.size(), 32'd0);

    $display("[TB] HALT at 00");
    clearMem();
    mem[8'h00] = 8'hF0;
    applyStimulus();
    step(1);
    checkOutput("halt_decode_halted", {31'd0, bus.halted}, 32'd0);
    step(1);
    checkOutput("halt_halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("halt_pc", {24'd0, bus.pc}, 32'h01);
    step(10);
    checkOutput("halt_pc_frozen", {24'd0, bus.pc}, 32'h01);
    checkOutput("halt_still_halted", {31'd0, bus.halted}, 32'd1);
    checkOutput("halt_alu_sel", {28'd0, bus.alu_sel}, 32'd0);

    $display("[TB] reset asserted during WB of ADD");
    clearMem();
    mem[8'h00] = 8'h11;
    aluZ = 1'b0; aluC = 1'b1;
    applyStimulus();
    step(3);
    checkOutput("wb_accum_we_before_reset", {31'd0, bus.accum_we}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("wb_reset_accum_we", {31'd0, bus.accum_we}, 32'd0);
    checkOutput("wb_reset_alu_sel", {28'd0, bus.alu_sel}, 32'd0);
    checkOutput("wb_reset_pc", {24'd0, bus.pc}, 32'h00);
    checkOutput("wb_reset_flags", {30'd0, bus.zf, bus.cf}, 32'd0);
    step(1);
    checkOutput("wb_reset_held_flags", {30'd0, bus.zf, bus.cf}, 32'd0);
    checkOutput("wb_reset_held_strobes", {29'd0, bus.accum_we, bus.reg_we, bus.halted}, 32'd0);
    rst = 1'b0;
    step(2);
    checkOutput("final_drained", expQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
